ext_pipe: RTL and testbench
===========================

Name: ext_pipe

Overview:
Parametrised, registered successor to the single-cycle immediate extender. Accepts an immediate plus an extension mode over a valid/ready handshake and returns the OUT_W-bit extended value one cycle later. The value is carried with a passthrough tag. A 2-entry skid buffer sustains full throughput without any combinational ready path. Sits between decode and execute, so downstream stalls never block on extender logic.

Parameters:
IN_W, 16, immediate width; legal range 2 <= IN_W < OUT_W.
OUT_W, 32, extended result width.
TAG_W, 5, width of the sideband tag carried with each beat (e.g. destination register number).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline flush; discards all held beats.
in_valid  in  1  input beat valid.
in_ready  out  1  unit can accept a beat this cycle; driven from a register.
in_imm  in  IN_W  immediate to extend.
in_mode  in  3  extension mode.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accepts the result.
out_data  out  OUT_W  extended result.
out_tag  out  TAG_W  tag of the result beat.
out_err  out  1  the current beat used a reserved mode.
err_seen  out  1  sticky flag: any reserved mode was accepted since reset.

Behaviour:
- Modes (U = OUT_W-IN_W):
  - 000 ZERO: U zeros, then imm.
  - 001 SIGN: U copies of imm[IN_W-1], then imm.
  - 010 LUI: imm << U (imm in the top IN_W bits, low U bits zero).
  - 011 ONE: U ones, then imm.
  - 100 SIGN_SHL2: the SIGN result shifted left by 2; the top 2 bits are dropped (branch offset).
  - 101/110/111: reserved. Data = 0, out_err = 1 on that beat, err_seen is set.
- Accept rule: a beat is accepted when in_valid && in_ready.
- Compute: the extension is combinational on the input side. Result, tag and err are registered at accept.
- Storage: main output register (out_*) plus a skid register (skid_valid, data, tag, err).
- in_ready = !skid_valid, registered. No combinational path from out_ready to in_ready.
- Latency is 1 cycle from accept to out_valid when the main register is empty or draining. Throughput is 1 beat/cycle while out_ready = 1.
- Per-cycle update, evaluated in priority order:
  1. reset: out_valid = 0, out_data = 0, out_tag = 0, out_err = 0, skid_valid = 0, in_ready = 1, err_seen = 0.
  2. flush: out_valid = 0, skid_valid = 0, in_ready = 1. Any beat offered that cycle is dropped. Data, tag and err registers may hold stale values. err_seen is unchanged.
  3. Main empty, or (out_valid && out_ready):
     - If skid_valid: main loads the skid contents and the skid takes the accepted beat, if any. Otherwise skid_valid is cleared.
     - Else: main loads the accepted beat; out_valid = accept.
  4. Main full and !out_ready:
     - An accepted beat goes to the skid; skid_valid = 1 and in_ready falls next cycle.
     - out_* is held stable.
- Ordering: beats leave strictly in accept order. No beat is lost or duplicated except by flush.
- Simultaneous accept and drain with the skid full cannot occur, because in_ready = 0 while the skid is full.
- Reset mid-stream: all held beats are dropped. The first beat after reset is accepted at the next edge at which in_valid = 1.
- While out_valid = 1 and out_ready = 0, out_data, out_tag and out_err are stable.

Decomposition:
- Package ext_pkg: the 3-bit mode constants EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_ONE, EXT_SIGN_SHL2, and the mode-width constant. Decode and control include the same package.
- Sub-module ext_core: purely combinational, parametrised IN_W/OUT_W. Maps (imm, mode) to (data, err). ext_pipe instantiates it once on the input side and adds handshake, skid and flags.

Test Plan:
- Modes, out_ready held 1, in_imm = 16'h8001:
  - ZERO -> 32'h00008001
  - SIGN -> 32'hFFFF8001
  - LUI -> 32'h80010000
  - ONE -> 32'hFFFF8001
  - SIGN_SHL2 -> 32'hFFFE0004
  - Each out_valid appears exactly 1 cycle after accept.
- Back-pressure: stream tags 1..6 with out_ready = 0 from cycle 2.
  - Tag 1 is held at the output and tag 2 goes to the skid.
  - in_ready falls on the next cycle and tag 3 waits.
  - Raising out_ready delivers tags 1..6 in order with no gaps or duplicates.
- Reserved mode 3'b110, imm = 16'h1234 -> out_data = 0, out_err = 1. err_seen = 1 and stays 1 through later good beats and through a flush. Reset clears it.
- Flush with main and skid both full, plus a beat offered the same cycle:
  - Next cycle out_valid = 0 and in_ready = 1.
  - The offered beat never appears at the output.
- Reset asserted mid-stream with out_ready = 0 -> next cycle out_valid = 0, out_data = 0, in_ready = 1. The first beat after release emerges with latency 1.
- Parameter sweep IN_W = 12, OUT_W = 16: SIGN of 12'h800 -> 16'hF800; LUI of 12'hABC -> 16'hABC0.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared mode encodings for the immediate extender datapath.
// Imported by decode and by the extender pipeline.
package ext_pkg;

    localparam int unsigned EXT_MODE_W = 3;

    typedef logic [EXT_MODE_W-1:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO      = 3'b000;
    localparam ext_mode_t EXT_SIGN      = 3'b001;
    localparam ext_mode_t EXT_LUI       = 3'b010;
    localparam ext_mode_t EXT_ONE       = 3'b011;
    localparam ext_mode_t EXT_SIGN_SHL2 = 3'b100;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: maps (imm, mode) to an OUT_W-bit value.
// Reserved modes produce zero data and raise err_c.
module ext_core
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  ext_mode_t        mode_i,
    output logic [OUT_W-1:0] data_c,
    output logic             err_c
);

    localparam int unsigned U_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_ext;

    always_comb begin
        sign_ext = {{U_W{imm_i[IN_W-1]}}, imm_i};
        data_c   = '0;
        err_c    = 1'b0;
        case (mode_i)
            EXT_ZERO:      data_c = {{U_W{1'b0}}, imm_i};
            EXT_SIGN:      data_c = sign_ext;
            EXT_LUI:       data_c = {imm_i, {U_W{1'b0}}};
            EXT_ONE:       data_c = {{U_W{1'b1}}, imm_i};
            EXT_SIGN_SHL2: data_c = sign_ext << 2;
            default:       err_c  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate extender with valid/ready handshake and a 2-entry skid
// buffer; in_ready is a flop so out_ready never reaches it combinationally.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  ext_mode_t        in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             err_seen
);

    logic [OUT_W-1:0] core_data_c;
    logic             core_err_c;
    logic             accept_c;

    logic             out_valid_q,  out_valid_d;
    logic [OUT_W-1:0] out_data_q,   out_data_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic             out_err_q,    out_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             skid_err_q,   skid_err_d;
    logic             in_ready_q,   in_ready_d;
    logic             err_seen_q,   err_seen_d;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (in_mode),
        .data_c (core_data_c),
        .err_c  (core_err_c)
    );

    assign accept_c = in_valid && in_ready_q;

    // Next-state for main register, skid register and flags.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        err_seen_d   = err_seen_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (!out_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = skid_data_q;
                    out_tag_d   = skid_tag_q;
                    out_err_d   = skid_err_q;
                    if (accept_c) begin
                        skid_data_d = core_data_c;
                        skid_tag_d  = in_tag;
                        skid_err_d  = core_err_c;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else begin
                    out_valid_d = accept_c;
                    if (accept_c) begin
                        out_data_d = core_data_c;
                        out_tag_d  = in_tag;
                        out_err_d  = core_err_c;
                    end
                end
            end else if (accept_c) begin
                // Main is stalled: park the new beat in the skid.
                skid_valid_d = 1'b1;
                skid_data_d  = core_data_c;
                skid_tag_d   = in_tag;
                skid_err_d   = core_err_c;
            end
            if (accept_c && core_err_c) begin
                err_seen_d = 1'b1;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            err_seen_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
            err_seen_q   <= err_seen_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
    assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed scenarios plus a randomized
// stream scored against a queue-based model of the extender.
module tb_ext_pipe;
    import ext_pkg::*;

    localparam int unsigned IN_W    = 16;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned P_IN_W  = 12;
    localparam int unsigned P_OUT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IN_W-1:0]  in_imm;
    ext_mode_t        in_mode;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [OUT_W-1:0] out_data;
    logic             out_err, err_seen;

    logic               p_reset = 1'b1, p_flush = 1'b0, p_in_valid = 1'b0, p_out_ready = 1'b1;
    logic               p_in_ready, p_out_valid, p_out_err, p_err_seen;
    logic [P_IN_W-1:0]  p_imm = '0;
    ext_mode_t          p_mode = EXT_ZERO;
    logic [TAG_W-1:0]   p_in_tag = '0, p_out_tag;
    logic [P_OUT_W-1:0] p_out_data;

    int checks = 0;
    int errors = 0;

    ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_err(out_err), .err_seen(err_seen)
    );

    ext_pipe #(.IN_W(P_IN_W), .OUT_W(P_OUT_W), .TAG_W(TAG_W)) dut_p (
        .clk(clk), .reset(p_reset), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_imm), .in_mode(p_mode), .in_tag(p_in_tag),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_tag(p_out_tag),
        .out_err(p_out_err), .err_seen(p_err_seen)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } beat_t;

    // Arithmetic model of the extension rules.
    function automatic logic [63:0] ref_ext(input logic [63:0] imm, input int mode,
                                            input int in_w, input int out_w);
        logic [63:0] full, top, s;
        full = 64'd1 << out_w;
        top  = 64'd1 << in_w;
        s    = (imm >= (top >> 1)) ? imm + full - top : imm;
        case (mode)
            0:       return imm;
            1:       return s;
            2:       return (imm * (64'd1 << (out_w - in_w))) % full;
            3:       return imm + full - top;
            4:       return (s * 64'd4) % full;
            default: return 64'd0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_mode = EXT_ZERO; in_tag = '0;
        cyc(); cyc();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL reset_err_seen: got %b expected 0", err_seen); end
    endtask

    task automatic test_modes();
        logic [OUT_W-1:0] exp_tab [5];
        exp_tab[0] = 32'h00008001; exp_tab[1] = 32'hFFFF8001; exp_tab[2] = 32'h80010000;
        exp_tab[3] = 32'hFFFF8001; exp_tab[4] = 32'hFFFE0004;
        out_ready = 1'b1;
        for (int m = 0; m < 5; m++) begin
            in_valid = 1'b1; in_imm = 16'h8001; in_mode = 3'(m); in_tag = 5'(m + 1);
            cyc();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b expected 1", m, out_valid); end
            checks++; if (out_data !== exp_tab[m]) begin errors++; $display("FAIL mode%0d_data: got %h expected %h", m, out_data, exp_tab[m]); end
            checks++; if (out_data !== OUT_W'(ref_ext(64'h8001, m, IN_W, OUT_W))) begin errors++; $display("FAIL mode%0d_model: got %h expected %h", m, out_data, OUT_W'(ref_ext(64'h8001, m, IN_W, OUT_W))); end
            checks++; if (out_tag !== 5'(m + 1) || out_err !== 1'b0) begin errors++; $display("FAIL mode%0d_tag_err: got %h/%b expected %h/0", m, out_tag, out_err, 5'(m + 1)); end
            cyc();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_single: got %b expected 0", m, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        int got [$];
        int first_cyc, last_cyc, next_tag;
        bit acc;
        out_ready = 1'b1; in_valid = 1'b1; in_mode = EXT_SIGN; in_imm = 16'($urandom); in_tag = 5'd1;
        cyc();
        out_ready = 1'b0; in_tag = 5'd2;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd1) begin errors++; $display("FAIL bp_hold1: got %b/%0d expected 1/1", out_valid, out_tag); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_fall: got %b expected 0", in_ready); end
        in_tag = 5'd3;
        cyc();
        checks++; if (out_tag !== 5'd1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got tag %0d ready %b expected 1/0", out_tag, in_ready); end
        out_ready = 1'b1; next_tag = 3; first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            in_valid = (next_tag <= 6); in_tag = 5'(next_tag);
            if (out_valid && out_ready) begin
                got.push_back(int'(out_tag));
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) next_tag++;
        end
        in_valid = 1'b0;
        checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_count: got %0d beats expected 6", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] != i + 1) begin errors++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got[i], i + 1); end
        end
        checks++; if (last_cyc - first_cyc != 5) begin errors++; $display("FAIL bp_gapless: got span %0d expected 5", last_cyc - first_cyc); end
        cyc();
    endtask

    task automatic test_reserved();
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 3'b110; in_imm = 16'h1234; in_tag = 5'd7;
        cyc();
        in_mode = EXT_ZERO; in_tag = 5'd8;
        checks++; if (out_valid !== 1'b1 || out_data !== '0 || out_err !== 1'b1) begin errors++; $display("FAIL rsv_beat: got v%b d%h e%b expected v1 d0 e1", out_valid, out_data, out_err); end
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL rsv_seen: got %b expected 1", err_seen); end
        cyc();
        in_valid = 1'b0;
        checks++; if (out_err !== 1'b0 || out_data !== 32'h00001234) begin errors++; $display("FAIL rsv_good_after: got e%b d%h expected e0 d00001234", out_err, out_data); end
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL rsv_sticky: got %b expected 1", err_seen); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL rsv_flush_keep: got %b expected 1", err_seen); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL rsv_reset_clear: got %b expected 0", err_seen); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_mode = EXT_ZERO; in_imm = 16'h00AA; in_tag = 5'd10;
        cyc();
        in_tag = 5'd11;
        cyc();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_full: got ready %b valid %b expected 0/1", in_ready, out_valid); end
        flush = 1'b1; in_tag = 5'd12;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got valid %b ready %b expected 0/1", out_valid, in_ready); end
        // Second case: main full, skid empty, offered beat would be accepted without the flush.
        in_valid = 1'b1; in_tag = 5'd13;
        cyc();
        flush = 1'b1; in_tag = 5'd14;
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped[%0d]: got valid %b tag %0d expected 0", c, out_valid, out_tag); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        logic [IN_W-1:0] imm;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = EXT_ONE; in_imm = 16'h0F0F; in_tag = 5'd19;
        cyc();
        in_tag = 5'd20;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: got v%b d%h r%b expected v0 d0 r1", out_valid, out_data, in_ready); end
        imm = 16'($urandom); in_imm = imm; in_mode = EXT_SIGN; in_tag = 5'd21;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd21) begin errors++; $display("FAIL rstmid_first: got v%b tag %0d expected v1 tag 21", out_valid, out_tag); end
        checks++; if (out_data !== OUT_W'(ref_ext(64'(imm), 1, IN_W, OUT_W))) begin errors++; $display("FAIL rstmid_data: got %h expected %h", out_data, OUT_W'(ref_ext(64'(imm), 1, IN_W, OUT_W))); end
        out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        beat_t q [$];
        beat_t b;
        bit acc, drn, exp_seen;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        cyc();
        reset = 1'b0; exp_seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            in_imm    = IN_W'($urandom);
            in_mode   = 3'($urandom_range(0, 7));
            in_tag    = TAG_W'($urandom);
            drn = out_valid && out_ready;
            acc = in_valid && in_ready && !flush;
            if (drn) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rnd_spurious[%0d]: got tag %0d expected no beat", c, out_tag); end
                else if (out_data !== q[0].data || out_tag !== q[0].tag || out_err !== q[0].err) begin
                    errors++; $display("FAIL rnd_beat[%0d]: got %h/%0d/%b expected %h/%0d/%b", c, out_data, out_tag, out_err, q[0].data, q[0].tag, q[0].err);
                end
            end
            b.data = OUT_W'(ref_ext(64'(in_imm), int'(in_mode), IN_W, OUT_W));
            b.tag  = in_tag;
            b.err  = (in_mode > 3'd4);
            cyc();
            if (flush) q.delete();
            else begin
                if (drn && q.size() > 0) void'(q.pop_front());
                if (acc) begin q.push_back(b); exp_seen = exp_seen | b.err; end
            end
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, in_ready, q.size() < 2); end
            checks++; if (err_seen !== exp_seen) begin errors++; $display("FAIL rnd_err_seen[%0d]: got %b expected %b", c, err_seen, exp_seen); end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
    endtask

    task automatic test_param();
        p_reset = 1'b0; p_out_ready = 1'b1; p_in_valid = 1'b1; p_imm = 12'h800; p_mode = EXT_SIGN; p_in_tag = 5'd3;
        cyc();
        p_imm = 12'hABC; p_mode = EXT_LUI; p_in_tag = 5'd4;
        checks++; if (p_out_valid !== 1'b1 || p_out_data !== 16'hF800) begin errors++; $display("FAIL param_sign: got v%b d%h expected v1 dF800", p_out_valid, p_out_data); end
        cyc();
        p_in_valid = 1'b0;
        checks++; if (p_out_valid !== 1'b1 || p_out_data !== 16'hABC0 || p_out_tag !== 5'd4) begin errors++; $display("FAIL param_lui: got v%b d%h t%0d expected v1 dABC0 t4", p_out_valid, p_out_data, p_out_tag); end
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_reserved();
        test_flush();
        test_reset_mid();
        test_random();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
